end_screen_ctrl: RTL and testbench

Sequencer for the end-of-game overlays. Sits between the game logic and the overlay draw stages (you-win, game-over). It latches the end condition, drives the overlay select flags, blinks the overlay lettering on a frame basis, freezes gameplay, and issues a restart request once the player presses the restart key after a minimum hold time.

---
 rtl/snake_pkg.sv | 17 +
 rtl/end_screen_ctrl_if.sv | 28 ++
 rtl/sync_edge.sv | 54 +++++
 rtl/end_screen_ctrl.sv | 141 ++++++++++++++
 tb/tb_end_screen_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared encodings and defaults for the end-of-game sequencer and the overlay draw stages.
package snake_pkg;

   localparam int unsigned STATE_W          = 3;
   localparam int unsigned DEF_BLINK_FRAMES = 30;
   localparam int unsigned DEF_HOLD_FRAMES  = 120;

   // Debug encoding on state_out; draw stages decode the same values.
   typedef enum logic [STATE_W-1:0] {
      PLAY     = 3'd0,
      WIN      = 3'd1,
      LOSE     = 3'd2,
      WAIT_KEY = 3'd3,
      RESTART  = 3'd4
   } state_e;

endpackage

// File: rtl/end_screen_ctrl_if.sv
// Game-logic and overlay-side signals of the end-of-game sequencer.
interface end_screen_ctrl_if;
   import snake_pkg::*;

   logic               vsync_in;
   logic               victory_in;
   logic               game_over_in;
   logic               key_restart;
   logic               victory_out;
   logic               game_over_out;
   logic               text_on;
   logic               freeze_out;
   logic               restart_out;
   logic [STATE_W-1:0] state_out;

   // Game logic / timing chain side.
   modport master (
      output vsync_in, victory_in, game_over_in, key_restart,
      input  victory_out, game_over_out, text_on, freeze_out, restart_out, state_out
   );

   // Sequencer side.
   modport slave (
      input  vsync_in, victory_in, game_over_in, key_restart,
      output victory_out, game_over_out, text_on, freeze_out, restart_out, state_out
   );

endinterface

// File: rtl/sync_edge.sv
// Optional 2-flop synchroniser followed by a registered rising-edge pulse.
module sync_edge #(
   parameter bit SYNC = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic pulse
);

   logic lvl;
   logic prev_q;
   logic edge_q;
   logic edge_d;

   if (SYNC) begin : g_sync
      logic s1_q;
      logic s2_q;

      // Two-stage metastability filter for an asynchronous input.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
         end else begin
            s1_q <= din;
            s2_q <= s1_q;
         end
      end

      assign lvl = s2_q;
   end else begin : g_nosync
      assign lvl = din;
   end

   // Rising edge relative to the previous sampled level.
   always_comb begin
      edge_d = lvl & ~prev_q;
   end

   // Previous-level and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         prev_q <= lvl;
         edge_q <= edge_d;
      end
   end

   assign pulse = edge_q;

endmodule

// File: rtl/end_screen_ctrl.sv
// End-of-game sequencer: latches win/lose, blinks overlay text, holds, then issues restart.
module end_screen_ctrl
   import snake_pkg::*;
#(
   parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES,
   parameter int unsigned HOLD_FRAMES  = DEF_HOLD_FRAMES,
   parameter int unsigned CNT_W        = 8
) (
   input  logic              pclk,
   input  logic              rst,
   end_screen_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [CNT_W-1:0] HOLD_CNT   = CNT_W'(HOLD_FRAMES);

   logic frame_tick;
   logic key_edge;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             text_on_q, text_on_d;
   logic             victory_q, victory_d;
   logic             game_over_q, game_over_d;
   logic             freeze_q, freeze_d;
   logic             restart_q, restart_d;

   // Restart key is asynchronous and needs synchronising.
   sync_edge #(.SYNC(1'b1)) u_key_edge (
      .clk   (pclk),
      .rst_n (rst),
      .din   (bus.key_restart),
      .pulse (key_edge)
   );

   // vsync is already in the pclk domain; edge detection only.
   sync_edge #(.SYNC(1'b0)) u_vsync_edge (
      .clk   (pclk),
      .rst_n (rst),
      .din   (bus.vsync_in),
      .pulse (frame_tick)
   );

   // Next-state, counter and output computation.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      blink_cnt_d = blink_cnt_q;
      text_on_d   = text_on_q;
      victory_d   = victory_q;
      game_over_d = game_over_q;
      restart_d   = 1'b0;

      // Lettering blinks in every overlay state, including the hold-expiry tick.
      if (frame_tick && (state_q == WIN || state_q == LOSE || state_q == WAIT_KEY)) begin
         if (blink_cnt_q >= BLINK_LAST) begin
            blink_cnt_d = '0;
            text_on_d   = ~text_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
         end
      end

      case (state_q)
         PLAY: begin
            // Victory wins a same-cycle tie with game over.
            if (bus.victory_in || bus.game_over_in) begin
               state_d     = bus.victory_in ? WIN : LOSE;
               victory_d   = bus.victory_in;
               game_over_d = ~bus.victory_in;
               text_on_d   = 1'b1;
               frame_cnt_d = '0;
               blink_cnt_d = '0;
            end
         end
         WIN, LOSE: begin
            // Key edges are ignored here, including one on the expiry tick.
            if (frame_tick) begin
               if (frame_cnt_q != HOLD_CNT) begin
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
               end
               if (frame_cnt_d == HOLD_CNT) begin
                  state_d = WAIT_KEY;
               end
            end
         end
         WAIT_KEY: begin
            if (key_edge) begin
               state_d     = RESTART;
               restart_d   = 1'b1;
               victory_d   = 1'b0;
               game_over_d = 1'b0;
               text_on_d   = 1'b0;
            end
         end
         RESTART: begin
            // Wait for game logic to drop both flags so the old result cannot retrigger.
            if (!bus.victory_in && !bus.game_over_in) begin
               state_d = PLAY;
            end
         end
         default: begin
            state_d = PLAY;
         end
      endcase

      freeze_d = (state_d != PLAY);
   end

   // State, counter and output registers.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state_q     <= PLAY;
         frame_cnt_q <= '0;
         blink_cnt_q <= '0;
         text_on_q   <= 1'b0;
         victory_q   <= 1'b0;
         game_over_q <= 1'b0;
         freeze_q    <= 1'b0;
         restart_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         text_on_q   <= text_on_d;
         victory_q   <= victory_d;
         game_over_q <= game_over_d;
         freeze_q    <= freeze_d;
         restart_q   <= restart_d;
      end
   end

   assign bus.victory_out   = victory_q;
   assign bus.game_over_out = game_over_q;
   assign bus.text_on       = text_on_q;
   assign bus.freeze_out    = freeze_q;
   assign bus.restart_out   = restart_q;
   assign bus.state_out     = state_q;

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Scoreboard bench for end_screen_ctrl with BLINK_FRAMES=2, HOLD_FRAMES=4.
// Output vector layout: {victory_out, game_over_out, text_on, freeze_out, restart_out, state_out[2:0]}.
module tb_end_screen_ctrl;

   typedef struct {
      int          cyc;
      string       tag;
      logic [7:0]  exp;
   } exp_t;

   logic pclk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_err = 0;
   int   n_chk = 0;
   exp_t sb[$];

   end_screen_ctrl_if bus ();

   end_screen_ctrl #(
      .BLINK_FRAMES (2),
      .HOLD_FRAMES  (4),
      .CNT_W        (8)
   ) dut (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (vo go txt frz rs st)", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] obs_vec();
      return {bus.victory_out, bus.game_over_out, bus.text_on,
              bus.freeze_out, bus.restart_out, bus.state_out};
   endfunction

   function automatic logic [7:0] v(input bit vo, input bit go, input bit tx,
                                     input bit fz, input bit rs, input logic [2:0] st);
      return {vo, go, tx, fz, rs, st};
   endfunction

   // Expected output vector at cycle (now + off).
   task automatic push(input string tag, input int off, input logic [7:0] e);
      exp_t item;
      item.cyc = cyc + off;
      item.tag = tag;
      item.exp = e;
      sb.push_back(item);
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   // One vsync pulse; pre is expected on the tick cycle, post once the FSM has seen it.
   task automatic frame(input string tag, input logic [7:0] pre, input logic [7:0] post);
      bus.vsync_in = 1'b1;
      push({tag, "_pre"}, 1, pre);
      push(tag, 2, post);
      step();
      bus.vsync_in = 1'b0;
      repeat (3) step();
   endtask

   // Compare every expectation that falls due in the current cycle.
   always @(negedge pclk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check_eq(sb[i].tag, obs_vec(), sb[i].exp);
            sb.delete(i);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst              = 1'b0;
      bus.vsync_in     = 1'b0;
      bus.victory_in   = 1'b0;
      bus.game_over_in = 1'b0;
      bus.key_restart  = 1'b0;
      repeat (2) step();
      check_eq("rst_init", obs_vec(), 8'h00);
      rst = 1'b1;
      repeat (3) step();
      check_eq("play_idle", obs_vec(), 8'h00);

      // Both flags at once selects WIN; then reset asynchronously mid-WIN.
      bus.victory_in   = 1'b1;
      bus.game_over_in = 1'b1;
      push("both_flags_win", 1, v(1, 0, 1, 1, 0, 3'd1));
      repeat (2) step();
      #2 rst = 1'b0;
      #1 check_eq("rst_async", obs_vec(), 8'h00);
      bus.victory_in   = 1'b0;
      bus.game_over_in = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      repeat (3) step();
      check_eq("rst_release_play", obs_vec(), 8'h00);

      // Victory path with blink, hold and restart.
      bus.victory_in = 1'b1;
      push("win_entry", 1, v(1, 0, 1, 1, 0, 3'd1));
      repeat (2) step();
      frame("win_f1", v(1, 0, 1, 1, 0, 3'd1), v(1, 0, 1, 1, 0, 3'd1));
      frame("win_f2", v(1, 0, 1, 1, 0, 3'd1), v(1, 0, 0, 1, 0, 3'd1));
      frame("win_f3", v(1, 0, 0, 1, 0, 3'd1), v(1, 0, 0, 1, 0, 3'd1));
      frame("win_f4", v(1, 0, 0, 1, 0, 3'd1), v(1, 0, 1, 1, 0, 3'd3));
      frame("wait_f5", v(1, 0, 1, 1, 0, 3'd3), v(1, 0, 1, 1, 0, 3'd3));
      frame("wait_f6", v(1, 0, 1, 1, 0, 3'd3), v(1, 0, 0, 1, 0, 3'd3));
      bus.key_restart = 1'b1;
      push("wk_not_yet", 3, v(1, 0, 0, 1, 0, 3'd3));
      push("wk_restart", 4, v(0, 0, 0, 1, 1, 3'd4));
      push("rs_one_cycle", 5, v(0, 0, 0, 1, 0, 3'd4));
      repeat (8) step();
      bus.key_restart = 1'b0;
      repeat (4) step();
      push("rs_stale_victory", 1, v(0, 0, 0, 1, 0, 3'd4));
      step();
      bus.victory_in = 1'b0;
      push("rs_to_play", 1, v(0, 0, 0, 0, 0, 3'd0));
      push("play_stays", 2, v(0, 0, 0, 0, 0, 3'd0));
      repeat (3) step();

      // Lose path: early key ignored, key on the hold tick discarded.
      bus.game_over_in = 1'b1;
      push("lose_entry", 1, v(0, 1, 1, 1, 0, 3'd2));
      repeat (2) step();
      frame("lose_f1", v(0, 1, 1, 1, 0, 3'd2), v(0, 1, 1, 1, 0, 3'd2));
      bus.key_restart = 1'b1;
      push("lose_key_ign4", 4, v(0, 1, 1, 1, 0, 3'd2));
      push("lose_key_ign5", 5, v(0, 1, 1, 1, 0, 3'd2));
      step();
      bus.key_restart = 1'b0;
      repeat (6) step();
      frame("lose_f2", v(0, 1, 1, 1, 0, 3'd2), v(0, 1, 0, 1, 0, 3'd2));
      frame("lose_f3", v(0, 1, 0, 1, 0, 3'd2), v(0, 1, 0, 1, 0, 3'd2));
      bus.key_restart = 1'b1;
      repeat (2) step();
      bus.vsync_in = 1'b1;
      push("hold_tick_pre", 1, v(0, 1, 0, 1, 0, 3'd2));
      push("hold_tick_wait", 2, v(0, 1, 1, 1, 0, 3'd3));
      push("hold_key_disc", 3, v(0, 1, 1, 1, 0, 3'd3));
      step();
      bus.vsync_in    = 1'b0;
      bus.key_restart = 1'b0;
      repeat (4) step();

      // Bouncing key gives a single restart pulse; game_over held stays in RESTART.
      bus.key_restart = 1'b1;
      push("bounce_restart", 4, v(0, 0, 0, 1, 1, 3'd4));
      push("bounce_p5", 5, v(0, 0, 0, 1, 0, 3'd4));
      push("bounce_p6", 6, v(0, 0, 0, 1, 0, 3'd4));
      push("bounce_p7", 7, v(0, 0, 0, 1, 0, 3'd4));
      step();
      bus.key_restart = 1'b0;
      step();
      bus.key_restart = 1'b1;
      repeat (10) step();
      bus.key_restart = 1'b0;
      repeat (3) step();
      push("stale_game_over", 1, v(0, 0, 0, 1, 0, 3'd4));
      step();
      bus.game_over_in = 1'b0;
      push("stale_clear", 1, v(0, 0, 0, 0, 0, 3'd0));
      push("play_after", 2, v(0, 0, 0, 0, 0, 3'd0));
      repeat (4) step();

      check_eq("sb_drained", 8'(sb.size()), 8'h00);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
